// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB front-end:
// register offsets, status bit positions, IRQ bits and FSM states.
package uart_apb_pkg;

    localparam logic [2:0] REG_TXDATA   = 3'd0;
    localparam logic [2:0] REG_RXDATA   = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_STAT = 3'd4;

    localparam int TX_EMPTY  = 2;
    localparam int TX_FULL   = 1;
    localparam int RX_EMPTY  = 2;
    localparam int RX_ERR_LO = 3;
    localparam int RX_ERR_HI = 6;

    localparam int IRQ_RX_AVAIL = 0;
    localparam int IRQ_TX_EMPTY = 1;
    localparam int IRQ_RX_ERR   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RD_POP,
        RD_DONE
    } apb_state_t;

endpackage

// File: rtl/apb_bus_if.sv
// APB3 bus bundle between a CPU-side master and the UART front-end.
interface apb_bus_if #(
    parameter int ADDR_WIDTH  = 5,
    parameter int PDATA_WIDTH = 32
);
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_WIDTH-1:0]  paddr;
    logic [PDATA_WIDTH-1:0] pwdata;
    logic [PDATA_WIDTH-1:0] prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/uart_irq_ctrl.sv
// Interrupt status/enable registers: sticky RX error with W1C,
// level status bits, enable masking and the registered irq line.
module uart_irq_ctrl
    import uart_apb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_empty,
    input  logic       rx_empty,
    input  logic [3:0] rx_err_flags,
    input  logic       en_wr,
    input  logic [2:0] en_wdata,
    input  logic       w1c,
    output logic [2:0] irq_en,
    output logic [2:0] irq_stat,
    output logic       irq
);

    logic err_any;
    logic err_prev;
    logic err_edge;
    logic rx_err;

    assign err_any  = |rx_err_flags;
    assign err_edge = err_any & ~err_prev;

    always_comb begin
        irq_stat               = '0;
        irq_stat[IRQ_RX_AVAIL] = ~rx_empty;
        irq_stat[IRQ_TX_EMPTY] = tx_empty;
        irq_stat[IRQ_RX_ERR]   = rx_err;
    end

    // A new error edge outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_prev <= 1'b0;
            rx_err   <= 1'b0;
            irq_en   <= '0;
            irq      <= 1'b0;
        end else begin
            err_prev <= err_any;
            rx_err   <= err_edge | (rx_err & ~w1c);
            if (en_wr)
                irq_en <= en_wdata;
            irq <= |(irq_stat & irq_en);
        end
    end

endmodule

// File: rtl/uart_apb_if.sv
// APB3 slave that turns bus transfers into uart_protocol push/pop
// pulses and exposes the TX/RX status and interrupt registers.
module uart_apb_if
    import uart_apb_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int PDATA_WIDTH = 32
)(
    input  logic                 clk,
    input  logic                 reset_n,
    apb_bus_if.slave             apb,
    output logic                 write_data,
    output logic                 read_data,
    output logic [DATA_SIZE-1:0] bus_data_in,
    input  logic [DATA_SIZE-1:0] bus_data_out,
    input  logic [7:0]           TX_status_register,
    input  logic [7:0]           RX_status_register,
    output logic                 irq
);

    apb_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]  addr;
    logic [2:0]             reg_sel;
    logic                   acc, setup;
    logic                   rx_empty, tx_full;
    logic                   bad, pop, push;
    logic                   en_wr, w1c;
    logic [PDATA_WIDTH-1:0] rdata;
    logic [2:0]             irq_en, irq_stat;
    logic                   unused;

    assign addr     = apb.paddr;
    assign reg_sel  = addr[4:2];
    assign acc      = apb.psel & apb.penable;
    assign setup    = apb.psel & ~apb.penable;
    assign rx_empty = RX_status_register[RX_EMPTY];
    assign tx_full  = TX_status_register[TX_FULL];
    assign unused   = ^{addr[1:0], apb.pwdata[PDATA_WIDTH-1:DATA_SIZE]};

    always_comb begin
        bad   = 1'b0;
        pop   = 1'b0;
        rdata = '0;
        unique case (reg_sel)
            REG_TXDATA: bad = ~apb.pwrite | tx_full;
            REG_RXDATA: begin
                bad = apb.pwrite | rx_empty;
                pop = ~bad;
            end
            REG_STATUS: begin
                bad         = apb.pwrite;
                rdata[15:0] = {RX_status_register, TX_status_register};
            end
            REG_IRQ_EN:   rdata[2:0] = irq_en;
            REG_IRQ_STAT: rdata[2:0] = irq_stat;
            default:      bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx    = state;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        read_data   = 1'b0;
        push        = 1'b0;
        en_wr       = 1'b0;
        w1c         = 1'b0;
        unique case (state)
            IDLE, RD_DONE: state_nx = setup ? ACCESS : IDLE;
            ACCESS: begin
                state_nx = IDLE;
                if (acc && pop) begin
                    read_data = 1'b1;
                    state_nx  = RD_POP;
                end else if (acc) begin
                    apb.pready  = 1'b1;
                    apb.pslverr = bad;
                    if (!bad && !apb.pwrite)
                        apb.prdata = rdata;
                    push  = apb.pwrite & ~bad & (reg_sel == REG_TXDATA);
                    en_wr = apb.pwrite & (reg_sel == REG_IRQ_EN);
                    w1c   = apb.pwrite & (reg_sel == REG_IRQ_STAT)
                          & apb.pwdata[IRQ_RX_ERR];
                end
            end
            RD_POP: begin
                // The pop is already issued; an abort just drops the data.
                state_nx = acc ? RD_DONE : IDLE;
                if (acc) begin
                    apb.pready                 = 1'b1;
                    apb.prdata[DATA_SIZE-1:0] = bus_data_out;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            write_data  <= 1'b0;
            bus_data_in <= '0;
        end else begin
            state      <= state_nx;
            write_data <= push;
            if (push)
                bus_data_in <= apb.pwdata[DATA_SIZE-1:0];
        end
    end

    uart_irq_ctrl u_irq (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_empty     (TX_status_register[TX_EMPTY]),
        .rx_empty     (rx_empty),
        .rx_err_flags (RX_status_register[RX_ERR_HI:RX_ERR_LO]),
        .en_wr        (en_wr),
        .en_wdata     (apb.pwdata[2:0]),
        .w1c          (w1c),
        .irq_en       (irq_en),
        .irq_stat     (irq_stat),
        .irq          (irq)
    );

endmodule

// File: tb/tb_uart_apb_if.sv
// Directed bench for uart_apb_if: register map, push/pop timing,
// error responses, interrupt sequencing and reset during a pop.
module tb_uart_apb_if;

    logic       clk;
    logic       reset_n;
    logic       write_data;
    logic       read_data;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;
    logic [7:0] tx_st;
    logic [7:0] rx_st;
    logic       irq;
    int         checks;
    int         errors;

    apb_bus_if #(.ADDR_WIDTH(5), .PDATA_WIDTH(32)) apb ();

    uart_apb_if #(
        .DATA_SIZE(8), .ADDR_WIDTH(5), .PDATA_WIDTH(32)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .apb                (apb),
        .write_data         (write_data),
        .read_data          (read_data),
        .bus_data_in        (bus_data_in),
        .bus_data_out       (bus_data_out),
        .TX_status_register (tx_st),
        .RX_status_register (rx_st),
        .irq                (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic setup(input logic [4:0] a, input logic w,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.paddr   = a;
        apb.pwrite  = w;
        apb.pwdata  = d;
    endtask

    task automatic access();
        @(posedge clk);
        #1;
        apb.penable = 1'b1;
        #2;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        apb.psel     = 1'b0;
        apb.penable  = 1'b0;
        apb.pwrite   = 1'b0;
        apb.paddr    = '0;
        apb.pwdata   = '0;
        bus_data_out = '0;
        tx_st        = 8'h00;
        rx_st        = 8'h04;
        #3;
        checks++;
        if ({apb.pready, apb.pslverr, write_data, read_data, irq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {apb.pready, apb.pslverr, write_data, read_data, irq});
        end
        checks++;
        if (apb.prdata !== 32'h0 || bus_data_in !== 8'h0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h exp=0/0",
                     apb.prdata, bus_data_in);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        setup(5'h0C, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h0 || apb.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq_en got=%h err=%b exp=0 err=0",
                     apb.prdata, apb.pslverr);
        end
        idle();
    endtask

    task automatic test_tx_write();
        tx_st = 8'h00;
        setup(5'h00, 1'b1, 32'h0000_00A5);
        access();
        checks++;
        if (apb.pready !== 1'b1 || apb.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL tx_resp got=%b%b exp=10",
                     apb.pready, apb.pslverr);
        end
        checks++;
        if (write_data !== 1'b0) begin
            errors++;
            $display("FAIL tx_early_push got=%b exp=0", write_data);
        end
        idle();
        checks++;
        if (write_data !== 1'b1 || bus_data_in !== 8'hA5) begin
            errors++;
            $display("FAIL tx_push got=%b/%h exp=1/a5",
                     write_data, bus_data_in);
        end
        @(posedge clk);
        #3;
        checks++;
        if (write_data !== 1'b0) begin
            errors++;
            $display("FAIL tx_pulse_len got=%b exp=0", write_data);
        end
    endtask

    task automatic test_tx_full();
        tx_st = 8'h02;
        setup(5'h00, 1'b1, 32'h0000_005A);
        access();
        checks++;
        if (apb.pready !== 1'b1 || apb.pslverr !== 1'b1) begin
            errors++;
            $display("FAIL txfull_resp got=%b%b exp=11",
                     apb.pready, apb.pslverr);
        end
        idle();
        checks++;
        if (write_data !== 1'b0 || bus_data_in !== 8'hA5) begin
            errors++;
            $display("FAIL txfull_nopush got=%b/%h exp=0/a5",
                     write_data, bus_data_in);
        end
        tx_st = 8'h00;
    endtask

    task automatic test_rx_read();
        rx_st        = 8'h00;
        bus_data_out = 8'h3C;
        setup(5'h04, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.pready !== 1'b0 || read_data !== 1'b1) begin
            errors++;
            $display("FAIL rx_cyc1 got=rdy%b pop%b exp=rdy0 pop1",
                     apb.pready, read_data);
        end
        @(posedge clk);
        #3;
        checks++;
        if (apb.pready !== 1'b1 || apb.prdata !== 32'h3C
            || apb.pslverr !== 1'b0 || read_data !== 1'b0) begin
            errors++;
            $display("FAIL rx_cyc2 got=%b %h %b %b exp=1 3c 0 0",
                     apb.pready, apb.prdata, apb.pslverr, read_data);
        end
        idle();
        checks++;
        if (apb.pready !== 1'b0 || apb.prdata !== 32'h0) begin
            errors++;
            $display("FAIL rx_after got=%b %h exp=0 0",
                     apb.pready, apb.prdata);
        end
    endtask

    task automatic test_rx_empty();
        rx_st = 8'h04;
        tx_st = 8'h04;
        setup(5'h04, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.pready !== 1'b1 || apb.pslverr !== 1'b1
            || apb.prdata !== 32'h0 || read_data !== 1'b0) begin
            errors++;
            $display("FAIL rxempty got=%b %b %h %b exp=1 1 0 0",
                     apb.pready, apb.pslverr, apb.prdata, read_data);
        end
        setup(5'h08, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h0000_0404 || apb.pslverr !== 1'b0) begin
            errors++;
            $display("FAIL status got=%h err=%b exp=00000404 err=0",
                     apb.prdata, apb.pslverr);
        end
        idle();
        tx_st = 8'h00;
    endtask

    task automatic test_irq();
        rx_st = 8'h04;
        tx_st = 8'h00;
        setup(5'h0C, 1'b1, 32'h4);
        access();
        idle();
        setup(5'h0C, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h4) begin
            errors++;
            $display("FAIL irq_en_rd got=%h exp=4", apb.prdata);
        end
        idle();
        @(posedge clk);
        #1;
        rx_st = 8'h0C;
        @(posedge clk);
        #1;
        rx_st = 8'h04;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency got=%b exp=0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got=%b exp=1", irq);
        end
        setup(5'h10, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h4) begin
            errors++;
            $display("FAIL irq_stat_rd got=%h exp=4", apb.prdata);
        end
        setup(5'h10, 1'b1, 32'h4);
        access();
        idle();
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c got=%b exp=0", irq);
        end
        tx_st = 8'h04;
        rx_st = 8'h00;
        setup(5'h10, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h3) begin
            errors++;
            $display("FAIL irq_levels got=%h exp=3", apb.prdata);
        end
        idle();
        tx_st = 8'h00;
        rx_st = 8'h04;
        @(posedge clk);
        #1;
        rx_st = 8'h0C;
        @(posedge clk);
        #1;
        rx_st = 8'h04;
        @(posedge clk);
        setup(5'h10, 1'b1, 32'h4);
        @(posedge clk);
        #1;
        apb.penable = 1'b1;
        rx_st       = 8'h0C;
        #2;
        idle();
        setup(5'h10, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.prdata !== 32'h4) begin
            errors++;
            $display("FAIL irq_set_wins got=%h exp=4", apb.prdata);
        end
        idle();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins_line got=%b exp=1", irq);
        end
        rx_st = 8'h04;
    endtask

    task automatic test_errors();
        logic [4:0]  a [4];
        logic        w [4];
        a = '{5'h18, 5'h18, 5'h08, 5'h00};
        w = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            setup(a[i], w[i], 32'hFF);
            access();
            checks++;
            if (apb.pready !== 1'b1 || apb.pslverr !== 1'b1
                || apb.prdata !== 32'h0) begin
                errors++;
                $display("FAIL err_%0d got=%b %b %h exp=1 1 0",
                         i, apb.pready, apb.pslverr, apb.prdata);
            end
            idle();
            checks++;
            if (write_data !== 1'b0) begin
                errors++;
                $display("FAIL err_push_%0d got=%b exp=0", i, write_data);
            end
        end
    endtask

    task automatic test_abort();
        setup(5'h00, 1'b1, 32'h77);
        @(posedge clk);
        #1;
        apb.psel = 1'b0;
        #2;
        checks++;
        if (apb.pready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rdy got=%b exp=0", apb.pready);
        end
        @(posedge clk);
        #3;
        checks++;
        if (write_data !== 1'b0 || bus_data_in !== 8'hA5) begin
            errors++;
            $display("FAIL abort_push got=%b/%h exp=0/a5",
                     write_data, bus_data_in);
        end
    endtask

    task automatic test_back_to_back();
        tx_st = 8'h00;
        rx_st = 8'h04;
        setup(5'h00, 1'b1, 32'h11);
        access();
        setup(5'h00, 1'b1, 32'h22);
        #2;
        checks++;
        if (write_data !== 1'b1 || bus_data_in !== 8'h11) begin
            errors++;
            $display("FAIL b2b_first got=%b/%h exp=1/11",
                     write_data, bus_data_in);
        end
        access();
        checks++;
        if (apb.pready !== 1'b1 || write_data !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got=%b/%b exp=1/0",
                     apb.pready, write_data);
        end
        setup(5'h08, 1'b0, 32'h0);
        #2;
        checks++;
        if (write_data !== 1'b1 || bus_data_in !== 8'h22) begin
            errors++;
            $display("FAIL b2b_push2 got=%b/%h exp=1/22",
                     write_data, bus_data_in);
        end
        access();
        checks++;
        if (apb.prdata !== 32'h0400) begin
            errors++;
            $display("FAIL b2b_status got=%h exp=00000400", apb.prdata);
        end
        rx_st        = 8'h00;
        tx_st        = 8'h04;
        bus_data_out = 8'h5E;
        setup(5'h04, 1'b0, 32'h0);
        access();
        @(posedge clk);
        #3;
        checks++;
        if (apb.pready !== 1'b1 || apb.prdata !== 32'h5E) begin
            errors++;
            $display("FAIL b2b_rx got=%b %h exp=1 5e",
                     apb.pready, apb.prdata);
        end
        setup(5'h08, 1'b0, 32'h0);
        access();
        checks++;
        if (apb.pready !== 1'b1 || apb.prdata !== 32'h0004) begin
            errors++;
            $display("FAIL b2b_after_rx got=%b %h exp=1 00000004",
                     apb.pready, apb.prdata);
        end
        idle();
        tx_st = 8'h00;
    endtask

    task automatic test_reset_mid_pop();
        int pops;
        rx_st        = 8'h00;
        bus_data_out = 8'h99;
        setup(5'h04, 1'b0, 32'h0);
        access();
        checks++;
        if (read_data !== 1'b1) begin
            errors++;
            $display("FAIL rst_pop_pre got=%b exp=1", read_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({apb.pready, apb.pslverr, write_data, read_data, irq} !== 5'b0
            || apb.prdata !== 32'h0 || bus_data_in !== 8'h0) begin
            errors++;
            $display("FAIL rst_pop got=%b%b%b%b%b %h %h exp=00000 0 0",
                     apb.pready, apb.pslverr, write_data, read_data, irq,
                     apb.prdata, bus_data_in);
        end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pops    = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #3;
            if (read_data !== 1'b0 || apb.pready !== 1'b0)
                pops++;
        end
        checks++;
        if (pops !== 0) begin
            errors++;
            $display("FAIL rst_no_pop got=%0d exp=0", pops);
        end
        rx_st = 8'h04;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tx_write();
        test_tx_full();
        test_rx_read();
        test_rx_empty();
        test_irq();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
